// File: rtl/link_pkg.sv
// link_pkg: definitions shared by the FSK loopback link blocks.
//   state_t  - frame controller state encoding (3 bits)
//   BYTE_W   - width of a payload byte
//   PREAMBLE - two-bit preamble that precedes each Hamming-framed word
package link_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] PREAMBLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_TX = 3'd2,
        WAIT_RX = 3'd3,
        CHECK   = 3'd4,
        RETRY   = 3'd5
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that holds at all-ones instead of wrapping.
//   clk   - clock, rising edge
//   clear - synchronous clear, has priority over inc
//   inc   - add one this cycle (ignored once the count is all-ones)
//   count - current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/link_frame_ctrl.sv
// link_frame_ctrl: frame scheduler for the FSK loopback link.
// Accepts a byte from the requester, launches it into the Tx chain, waits for
// the Rx chain to return a decoded byte, compares, and resends on mismatch or
// timeout until the retry allowance is used up.
//   sys_clk, rst          - clock and synchronous active-high reset
//   req_valid/req_data    - requester byte, accepted when req_ready is high
//   req_ready             - high in IDLE while not in reset
//   tx_start/tx_data      - one-cycle launch pulse and the byte to send
//   tx_done               - Tx chain has finished shifting the frame out
//   rx_valid/rx_data      - decoded byte returned by the Rx chain
//   frame_ok/frame_fail   - one-cycle outcome pulses
//   busy                  - a frame is in progress
//   ok_cnt/err_cnt/retry_cnt - saturating statistics counters
module link_frame_ctrl
    import link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [BYTE_W-1:0] req_data,
    output logic              req_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              frame_ok,
    output logic              frame_fail,
    output logic              busy,
    output logic [CNT_W-1:0]  ok_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  retry_cnt
);

    // Timer must hold TIMEOUT_CYCLES-1; attempt must hold MAX_RETRY.
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ATT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_RETRY);

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [ATT_W-1:0]  attempt;
    logic [BYTE_W-1:0] rx_byte;

    logic timed_out;
    logic ok_inc;
    logic err_inc;
    logic retry_inc;

    assign req_ready = (state == IDLE) && !rst;
    assign timed_out = (timer == TMR_LAST);

    // Counter strobes coincide with the edge that raises frame_ok/frame_fail,
    // so the counters are already updated while the pulse is visible.
    assign ok_inc    = (state == CHECK) && (rx_byte == tx_data);
    assign retry_inc = (state == RETRY) && (attempt < ATT_MAX);
    assign err_inc   = (state == RETRY) && !(attempt < ATT_MAX);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_fail <= 1'b0;
            busy       <= 1'b0;
            tx_data    <= '0;
            attempt    <= '0;
            timer      <= '0;
        end else begin
            tx_start   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        tx_data <= req_data;
                        attempt <= '0;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    tx_start <= 1'b1;
                    timer    <= '0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    // rx_valid here is a leftover from an earlier attempt.
                    timer <= timer + TMR_W'(1);
                    if (tx_done) begin
                        state <= WAIT_RX;
                    end else if (timed_out) begin
                        state <= RETRY;
                    end
                end
                WAIT_RX: begin
                    // A byte arriving on the timeout cycle still gets checked.
                    timer <= timer + TMR_W'(1);
                    if (rx_valid) begin
                        rx_byte <= rx_data;
                        state   <= CHECK;
                    end else if (timed_out) begin
                        state <= RETRY;
                    end
                end
                CHECK: begin
                    if (rx_byte == tx_data) begin
                        frame_ok <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= RETRY;
                    end
                end
                RETRY: begin
                    if (attempt < ATT_MAX) begin
                        attempt <= attempt + ATT_W'(1);
                        state   <= SEND;
                    end else begin
                        frame_fail <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_ok_cnt (
        .clk   (sys_clk),
        .clear (rst),
        .inc   (ok_inc),
        .count (ok_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (sys_clk),
        .clear (rst),
        .inc   (err_inc),
        .count (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retry_cnt (
        .clk   (sys_clk),
        .clear (rst),
        .inc   (retry_inc),
        .count (retry_cnt)
    );

endmodule

// File: tb/tb_link_frame_ctrl.sv
// tb_link_frame_ctrl: scoreboard bench for link_frame_ctrl.
// Two instances share every input: one with 16-bit counters, one with 2-bit
// counters to observe saturation. A loopback responder plays the Tx/Rx chain
// according to a per-attempt script; a frame-level model turns each script
// into the expected sequence of tx_start / frame_ok / frame_fail events.
module tb_link_frame_ctrl;

    localparam int T   = 16;
    localparam int MR  = 3;
    localparam int CW  = 16;
    localparam int CWS = 2;

    typedef enum int {M_GOOD, M_BAD, M_TO_TX, M_TO_RX, M_LATE, M_EDGE, M_STALE} mode_e;
    typedef struct {
        mode_e      mode;
        logic [7:0] rx_byte;
    } att_t;
    typedef enum int {E_START, E_OK, E_FAIL} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
        int         gap;
        int         ok;
        int         err;
        int         rt;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [7:0]    req_data;
    logic          tx_done;
    logic          rx_valid;
    logic [7:0]    rx_data;

    logic          req_ready, tx_start, frame_ok, frame_fail, busy;
    logic [7:0]    tx_data;
    logic [CW-1:0] ok_cnt, err_cnt, retry_cnt;

    logic           s_req_ready, s_tx_start, s_frame_ok, s_frame_fail, s_busy;
    logic [7:0]     s_tx_data;
    logic [CWS-1:0] s_ok_cnt, s_err_cnt, s_retry_cnt;

    att_t script [MR+1];
    att_t mq[$];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_ok, m_err, m_rt;

    always #5 sys_clk = ~sys_clk;

    link_frame_ctrl #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR), .CNT_W(CW)) dut (
        .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_ok(frame_ok), .frame_fail(frame_fail), .busy(busy),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt), .retry_cnt(retry_cnt)
    );

    link_frame_ctrl #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR), .CNT_W(CWS)) dut_s (
        .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(s_req_ready), .tx_start(s_tx_start), .tx_data(s_tx_data),
        .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_ok(s_frame_ok), .frame_fail(s_frame_fail), .busy(s_busy),
        .ok_cnt(s_ok_cnt), .err_cnt(s_err_cnt), .retry_cnt(s_retry_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_lost(input mode_e m);
        return (m == M_TO_TX) || (m == M_TO_RX) || (m == M_LATE);
    endfunction

    function automatic int sat(input int x);
        return (x > (1 << CWS) - 1) ? (1 << CWS) - 1 : x;
    endfunction

    task automatic fill_script(input mode_e m, input logic [7:0] rb);
        for (int a = 0; a <= MR; a++) script[a] = '{mode: m, rx_byte: rb};
    endtask

    // Frame-level reference: an attempt succeeds when a byte comes back in time
    // and equals the byte sent; each failed attempt before the last is a retry.
    task automatic plan(input logic [7:0] b);
        exp_t e;
        int   gap  = 0;
        bit   done = 0;
        for (int a = 0; a <= MR && !done; a++) begin
            mq.push_back(script[a]);
            e = '{kind: E_START, data: b, gap: gap, ok: 0, err: 0, rt: 0};
            sbq.push_back(e);
            if (!is_lost(script[a].mode) && script[a].rx_byte == b) begin
                m_ok++;
                e = '{kind: E_OK, data: b, gap: 0, ok: m_ok, err: m_err, rt: m_rt};
                sbq.push_back(e);
                done = 1;
            end else if (a < MR) begin
                m_rt++;
                gap = is_lost(script[a].mode) ? T + 2 : 0;
            end else begin
                m_err++;
                e = '{kind: E_FAIL, data: b, gap: is_lost(script[a].mode) ? T + 1 : 0,
                      ok: m_ok, err: m_err, rt: m_rt};
                sbq.push_back(e);
            end
        end
    endtask

    task automatic issue(input logic [7:0] b, input bit hold);
        int n = 0;
        req_valid = 1'b1;
        req_data  = b;
        while (!req_ready && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("accept_wait", 32'(req_ready), 32'd1);
        @(negedge sys_clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("drain_events", 32'(sbq.size()), 32'd0);
        chk("drain_script", 32'(mq.size()), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic pulse_done(input int j);
        repeat (j) @(negedge sys_clk);
        tx_done = 1'b1;
        @(negedge sys_clk);
        tx_done = 1'b0;
    endtask

    task automatic pulse_rx(input int j, input logic [7:0] v);
        repeat (j) @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = v;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    // Loopback responder: negedge k after tx_start is seen drives a pulse that
    // the DUT samples k+1 edges after the tx_start edge.
    initial begin
        att_t cur;
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (tx_start && !rst && mq.size() != 0) begin
                cur = mq.pop_front();
                case (cur.mode)
                    M_GOOD, M_BAD: begin
                        pulse_done(int'($urandom_range(0, 6)));
                        pulse_rx(int'($urandom_range(0, 6)), cur.rx_byte);
                    end
                    M_TO_RX: pulse_done(1);
                    M_EDGE: begin
                        pulse_done(2);
                        pulse_rx(T - 4, cur.rx_byte);
                    end
                    M_LATE: begin
                        pulse_done(2);
                        pulse_rx(T - 3, cur.rx_byte);
                    end
                    M_STALE: begin
                        pulse_rx(1, ~cur.rx_byte);
                        pulse_done(1);
                        pulse_rx(2, cur.rx_byte);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: pops one expectation per observed pulse.
    initial begin
        int   since = 0;
        exp_t e;
        ev_e  k;
        forever begin
            @(negedge sys_clk);
            since++;
            if (rst) begin
                since = 0;
            end else begin
                chk("ready_vs_busy", 32'(req_ready), 32'(!busy));
                if (tx_start || frame_ok || frame_fail) begin
                    k = tx_start ? E_START : (frame_ok ? E_OK : E_FAIL);
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: got kind %0d want none at %0t", k, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("event_kind", 32'(k), 32'(e.kind));
                        chk("pulse_excl", 32'(tx_start) + 32'(frame_ok) + 32'(frame_fail), 32'd1);
                        if (k == E_START) chk("tx_data", 32'(tx_data), 32'(e.data));
                        if (e.gap != 0) chk("event_gap", 32'(since), 32'(e.gap));
                        if (k != E_START) begin
                            chk("ok_cnt", 32'(ok_cnt), 32'(e.ok));
                            chk("err_cnt", 32'(err_cnt), 32'(e.err));
                            chk("retry_cnt", 32'(retry_cnt), 32'(e.rt));
                            chk("sat_ok_cnt", 32'(s_ok_cnt), 32'(sat(e.ok)));
                            chk("sat_err_cnt", 32'(s_err_cnt), 32'(sat(e.err)));
                            chk("sat_retry_cnt", 32'(s_retry_cnt), 32'(sat(e.rt)));
                        end
                    end
                    if (tx_start) since = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got no completion want finish before %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = 8'h00;
        m_ok = 0; m_err = 0; m_rt = 0;
        repeat (3) @(negedge sys_clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_frame_ok", 32'(frame_ok), 32'd0);
        chk("rst_frame_fail", 32'(frame_fail), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_ok_cnt", 32'(ok_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(negedge sys_clk);

        // Clean loopback.
        fill_script(M_GOOD, 8'hA5);
        plan(8'hA5);
        issue(8'hA5, 0);
        drain();

        // One corrupted return, then a good one.
        fill_script(M_GOOD, 8'hA5);
        script[0] = '{mode: M_BAD, rx_byte: 8'hA4};
        plan(8'hA5);
        issue(8'hA5, 0);
        drain();

        // Persistent corruption exhausts the retries.
        fill_script(M_BAD, 8'h00);
        plan(8'h3C);
        issue(8'h3C, 0);
        drain();

        // Every attempt lost to timeout.
        b = 8'($urandom);
        for (int a = 0; a <= MR; a++) begin
            case ($urandom_range(0, 2))
                0:       script[a] = '{mode: M_TO_TX, rx_byte: b};
                1:       script[a] = '{mode: M_TO_RX, rx_byte: b};
                default: script[a] = '{mode: M_LATE, rx_byte: b};
            endcase
        end
        plan(b);
        issue(b, 0);
        drain();

        // Byte on the timeout cycle is accepted; one cycle later it is not.
        fill_script(M_EDGE, 8'h5A);
        plan(8'h5A);
        issue(8'h5A, 0);
        drain();
        fill_script(M_EDGE, 8'hC3);
        script[0] = '{mode: M_LATE, rx_byte: 8'hC3};
        plan(8'hC3);
        issue(8'hC3, 0);
        drain();

        // Reset while waiting for the Rx byte abandons the frame silently.
        mq.push_back('{mode: M_TO_RX, rx_byte: 8'h77});
        sbq.push_back('{kind: E_START, data: 8'h77, gap: 0, ok: 0, err: 0, rt: 0});
        issue(8'h77, 0);
        repeat (6) @(negedge sys_clk);
        chk("midframe_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge sys_clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_ok_cnt", 32'(ok_cnt), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mid_rst_retry_cnt", 32'(retry_cnt), 32'd0);
        chk("mid_rst_sat_ok_cnt", 32'(s_ok_cnt), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        m_ok = 0; m_err = 0; m_rt = 0;
        #1;
        chk("mid_rst_ready_after", 32'(req_ready), 32'd1);
        repeat (2 * T) @(negedge sys_clk);
        chk("mid_rst_quiet", 32'(sbq.size()) + 32'(busy), 32'd0);

        // Back-to-back with req_valid held, stale byte during WAIT_TX on frame 3.
        for (int i = 1; i <= 5; i++) begin
            fill_script(M_GOOD, 8'(i));
            if (i == 3) script[0] = '{mode: M_STALE, rx_byte: 8'(i)};
            plan(8'(i));
            issue(8'(i), i < 5);
        end
        drain();
        chk("b2b_ok_cnt", 32'(ok_cnt), 32'd5);
        chk("b2b_sat_ok_cnt", 32'(s_ok_cnt), 32'd3);

        // Random frames with random per-attempt channel behaviour.
        for (int f = 0; f < 25; f++) begin
            b = 8'($urandom);
            for (int a = 0; a <= MR; a++) begin
                script[a].mode    = mode_e'($urandom_range(0, 6));
                script[a].rx_byte = (script[a].mode == M_BAD) ? (b ^ 8'($urandom_range(1, 255))) : b;
            end
            plan(b);
            issue(b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) drain();
        end
        req_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
